// File: rtl/video_framebuffer_reader.sv
// Avalon-MM read master: fetches one raster-order frame from the SRAM framebuffer and
// emits it as a valid/ready pixel stream tagged with start-of-frame and end-of-line.
module video_framebuffer_reader #(
  parameter int unsigned AVN_AW          = 18,
  parameter int unsigned AVN_DW          = 16,
  parameter int unsigned RGB_SIZE        = 12,
  parameter int unsigned H_DISPLAY       = 640,
  parameter int unsigned V_DISPLAY       = 480,
  parameter int unsigned BUF_SIZE        = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err,
  output logic                  avn_read,
  output logic [AVN_AW-1:0]     avn_address,
  output logic [AVN_DW/8-1:0]   avn_byteenable,
  input  logic                  avn_waitrequest,
  input  logic [AVN_DW-1:0]     avn_readdata,
  input  logic                  avn_readdatavalid,
  output logic [RGB_SIZE-1:0]   pixel_rgb,
  output logic                  pixel_sof,
  output logic                  pixel_eol,
  output logic                  pixel_vld,
  input  logic                  pixel_rdy
);

  localparam int unsigned Total = H_DISPLAY * V_DISPLAY;
  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW    = $clog2(BUF_SIZE + 1);
  localparam int unsigned PW    = $clog2(BUF_SIZE);
  localparam int unsigned IW    = $clog2(Total + 1);
  localparam int unsigned HW    = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1;
  localparam int unsigned VW    = (V_DISPLAY > 1) ? $clog2(V_DISPLAY) : 1;
  localparam int unsigned EW    = RGB_SIZE + 2;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e              state_q, state_d;
  logic                read_q, read_d;
  logic [AVN_AW-1:0]   addr_q, addr_d;
  logic [IW-1:0]       issued_q, issued_d;
  logic [OW-1:0]       outst_q, outst_d;
  logic                ret_vld_q, ret_vld_d;
  logic [RGB_SIZE-1:0] ret_data_q, ret_data_d;
  logic [HW-1:0]       hc_q, hc_d;
  logic [VW-1:0]       vc_q, vc_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;
  logic                err_q, err_d;
  logic [EW-1:0]       mem_q [BUF_SIZE];
  logic [EW-1:0]       head;

  logic accept, push, pop, spurious, credit_ok;

  // outst_q also counts the return sitting in the staging register, so the bus-side
  // count of reads still in flight is outst_q - ret_vld_q.
  assign accept   = read_q & ~avn_waitrequest;
  assign push     = ret_vld_q;
  assign pop      = pixel_vld & pixel_rdy;
  assign spurious = avn_readdatavalid & (outst_q == OW'(ret_vld_q));

  generate
    if (AVN_DW > RGB_SIZE) begin : g_unused
      logic unused_rdata;
      assign unused_rdata = ^avn_readdata[AVN_DW-1:RGB_SIZE];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    hc_d       = hc_q;
    vc_d       = vc_q;
    frame_done = 1'b0;
    ret_vld_d  = avn_readdatavalid & ~spurious;
    ret_data_d = avn_readdatavalid ? avn_readdata[RGB_SIZE-1:0] : ret_data_q;
    err_d      = err_q | spurious;

    if (push) begin
      if (hc_q == HW'(H_DISPLAY - 1)) begin
        hc_d = '0;
        vc_d = (vc_q == VW'(V_DISPLAY - 1)) ? '0 : vc_q + VW'(1);
      end else begin
        hc_d = hc_q + HW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StIssue;
          addr_d   = '0;
          issued_d = '0;
          hc_d     = '0;
          vc_d     = '0;
        end
      end
      StIssue: begin
        if (accept) begin
          addr_d   = addr_q + AVN_AW'(1);
          issued_d = issued_q + IW'(1);
          if (issued_q == IW'(Total - 1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (outst_q == '0 && fcnt_q == CW'(1) && pop) begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    outst_d = outst_q;
    if (accept && !push)      outst_d = outst_q + OW'(1);
    else if (!accept && push) outst_d = outst_q - OW'(1);

    fcnt_d = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + CW'(1);
    else if (!push && pop) fcnt_d = fcnt_q - CW'(1);

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    // Credit is judged on next-state counts; a stalled request is held regardless.
    credit_ok = (32'(outst_d) + 32'(fcnt_d) < 32'(BUF_SIZE)) &&
                (32'(outst_d) < 32'(MAX_OUTSTANDING));
    if (read_q && avn_waitrequest) read_d = 1'b1;
    else read_d = (state_d == StIssue) && (32'(issued_d) < 32'(Total)) && credit_ok;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      read_q     <= 1'b0;
      addr_q     <= '0;
      issued_q   <= '0;
      outst_q    <= '0;
      ret_vld_q  <= 1'b0;
      ret_data_q <= '0;
      hc_q       <= '0;
      vc_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      outst_q    <= outst_d;
      ret_vld_q  <= ret_vld_d;
      ret_data_q <= ret_data_d;
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= {(hc_q == '0) && (vc_q == '0), hc_q == HW'(H_DISPLAY - 1),
                                  ret_data_q};
  end

  assert property (@(posedge sys_clk) disable iff (sys_rst)
                   !(push && !pop && fcnt_q == CW'(BUF_SIZE)));

  assign head           = mem_q[rd_ptr_q];
  assign pixel_vld      = (fcnt_q != '0);
  assign pixel_rgb      = pixel_vld ? head[RGB_SIZE-1:0] : '0;
  assign pixel_eol      = pixel_vld & head[RGB_SIZE];
  assign pixel_sof      = pixel_vld & head[RGB_SIZE+1];
  assign busy           = (state_q != StIdle);
  assign err            = err_q;
  assign avn_read       = read_q;
  assign avn_address    = addr_q;
  assign avn_byteenable = '1;

endmodule

// File: tb/tb_video_framebuffer_reader.sv
// Bench for video_framebuffer_reader: randomized Avalon slave and stream sink, with
// frames compared against a raster-order reference built from plain arithmetic.
module tb_video_framebuffer_reader;
  localparam int H = 4, V = 2, N = H * V, B = 4, M = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, frame_done, err, avn_read;
  logic [17:0] avn_address;
  logic [1:0]  avn_byteenable;
  logic        wreq = 1'b0;
  logic [15:0] rdata = '0;
  logic        rdv = 1'b0;
  logic [11:0] pixel_rgb;
  logic        pixel_sof, pixel_eol, pixel_vld;
  logic        rdy = 1'b0;

  always #5 clk = ~clk;

  video_framebuffer_reader #(
    .AVN_AW(18), .AVN_DW(16), .RGB_SIZE(12), .H_DISPLAY(H), .V_DISPLAY(V),
    .BUF_SIZE(B), .MAX_OUTSTANDING(M)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .err(err), .avn_read(avn_read), .avn_address(avn_address),
    .avn_byteenable(avn_byteenable), .avn_waitrequest(wreq), .avn_readdata(rdata),
    .avn_readdatavalid(rdv), .pixel_rgb(pixel_rgb), .pixel_sof(pixel_sof),
    .pixel_eol(pixel_eol), .pixel_vld(pixel_vld), .pixel_rdy(rdy)
  );

  typedef struct { int addr; int due; } ret_t;
  ret_t        rq[$];
  int          reads[$];
  logic [13:0] got[$];
  int          checks = 0, failures = 0;
  int          n = 0, lat = 1, wait_pct = 0, rdy_pct = 100;
  int          fd_cnt, fd_idx, max_out, outst, stall_viol, busy_viol, first_rdv, first_vld;
  int          k1 = 1, k2 = 0;
  bit          spur = 0, prev_stall = 0, prev_fd = 0;
  logic [17:0] prev_addr = '0;

  function automatic logic [11:0] pix_of(int a);
    return 12'((a * k1 + k2) & 32'hfff);
  endfunction

  function automatic logic [13:0] exp_pix(int i);
    return {i == 0, (i % H) == H - 1, pix_of(i)};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: slave and sink drive on the falling edge, then observe.
  task automatic tick();
    @(negedge clk);
    n++;
    if (prev_stall && (!avn_read || avn_address != prev_addr)) stall_viol++;
    if (prev_fd && busy) busy_viol++;
    if (rst) begin rq.delete(); outst = 0; end
    if (spur) begin
      rdv = 1'b1; rdata = 16'($urandom); spur = 0;
    end else if (rq.size() > 0 && rq[0].due <= n) begin
      rdv = 1'b1;
      rdata = {4'($urandom), pix_of(rq[0].addr)};
      void'(rq.pop_front());
      outst--;
      if (first_rdv < 0) first_rdv = n;
    end else begin
      rdv = 1'b0; rdata = 16'($urandom);
    end
    wreq = ($urandom_range(99) < wait_pct);
    rdy  = ($urandom_range(99) < rdy_pct);
    #1;
    if (avn_read && !wreq) begin
      reads.push_back(int'(avn_address));
      rq.push_back('{int'(avn_address), n + lat});
      outst++;
    end
    if (outst > max_out) max_out = outst;
    prev_stall = avn_read && wreq;
    prev_addr  = avn_address;
    if (pixel_vld && first_vld < 0) first_vld = n;
    if (pixel_vld && rdy) got.push_back({pixel_sof, pixel_eol, pixel_rgb});
    prev_fd = frame_done;
    if (frame_done) begin fd_cnt++; fd_idx = got.size(); end
  endtask

  task automatic clear_obs();
    got.delete(); reads.delete();
    fd_cnt = 0; fd_idx = -1; max_out = 0; stall_viol = 0; busy_viol = 0;
    first_rdv = -1; first_vld = -1; prev_fd = 0;
    k1 = $urandom_range(1, 4095); k2 = $urandom_range(0, 4095);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int b = 0;
    while ((busy || got.size() < N) && b < 600) begin tick(); b++; end
    check({tag, "_timeout"}, b < 600, 1);
  endtask

  task automatic check_frame(string tag);
    check({tag, "_npix"}, got.size(), N);
    for (int i = 0; i < N && i < got.size(); i++) check({tag, "_pix"}, got[i], exp_pix(i));
    check({tag, "_nreads"}, reads.size(), N);
    for (int i = 0; i < N && i < reads.size(); i++) check({tag, "_addr"}, reads[i], i);
    check({tag, "_fd_count"}, fd_cnt, 1);
    check({tag, "_fd_on_last"}, fd_idx, N);
    check({tag, "_busy_drop"}, busy_viol, 0);
    check({tag, "_stall_hold"}, stall_viol, 0);
    check({tag, "_max_outst"}, max_out <= M, 1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, frame_done, err, avn_read, avn_address, pixel_rgb, pixel_sof,
                pixel_eol, pixel_vld});
  endfunction

  initial begin
    // Reset state
    #1;
    check("rst_outputs", all_outs(), 0);
    check("rst_byteenable", avn_byteenable, 2'b11);
    tick(); tick();
    rst = 1'b0;

    // 1: zero-wait slave, always-ready sink
    clear_obs(); lat = 1; wait_pct = 0; rdy_pct = 100;
    pulse_start();
    check("t1_busy_after_start", busy, 1);
    check("t1_first_read", {avn_read, avn_address}, {1'b1, 18'd0});
    wait_idle("t1");
    check_frame("t1");
    check("t1_vld_latency", first_vld - first_rdv, 2);
    check("t1_err", err, 0);

    // 2: random waitrequest and sink backpressure
    for (int r = 0; r < 3; r++) begin
      clear_obs(); lat = $urandom_range(1, 3); wait_pct = 50; rdy_pct = 70;
      pulse_start();
      wait_idle("t2");
      check_frame("t2");
    end

    // 3: sink stalled for 20 cycles
    clear_obs(); lat = 1; wait_pct = 0; rdy_pct = 0;
    pulse_start();
    repeat (20) tick();
    check("t3_reads_bounded", reads.size() <= B, 1);
    check("t3_head_held", {pixel_vld, pixel_sof, pixel_rgb}, {2'b11, pix_of(0)});
    check("t3_no_pops", got.size(), 0);
    rdy_pct = 100;
    wait_idle("t3");
    check_frame("t3");

    // 4: long slave latency
    clear_obs(); lat = 5; wait_pct = 0; rdy_pct = 100;
    pulse_start();
    wait_idle("t4");
    check_frame("t4");

    // 5: start while busy is ignored; a later start runs a fresh frame
    clear_obs(); lat = 2; wait_pct = 20; rdy_pct = 100;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    wait_idle("t5a");
    check_frame("t5a");
    repeat (3) tick();
    check("t5_idle_after", busy, 0);
    clear_obs();
    pulse_start();
    wait_idle("t5b");
    check_frame("t5b");

    // 6: reset mid-frame, spurious return, then a clean frame with err sticky
    clear_obs(); lat = 3; wait_pct = 0; rdy_pct = 50;
    pulse_start();
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check("t6_rst_outputs", all_outs(), 0);
    tick(); tick();
    check("t6_rst_outputs_held", all_outs(), 0);
    rst = 1'b0;
    tick();
    check("t6_err_before", err, 0);
    spur = 1;
    tick(); tick();
    check("t6_err_set", err, 1);
    check("t6_idle", busy, 0);
    clear_obs(); lat = 1; rdy_pct = 100;
    pulse_start();
    wait_idle("t6");
    check_frame("t6");
    check("t6_err_sticky", err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", n);
    $fatal(1);
  end
endmodule
